// File: rtl/sobel_gcd_spi_pkg.sv
// Shared types and command-word fields for the sobel/GCD SPI link.
// SPI_MASTER_BYTE_SWAP_EN selects low-byte-first wire order in wire_bit_idx().
package sobel_gcd_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP
  } state_e;

  localparam int CMD_SOBEL_BIT = 15;
  localparam int OP_SEL_MSB    = 14;
  localparam int OP_SEL_LSB    = 13;
  localparam logic [1:0] OP_SEL_A = 2'b00;
  localparam logic [1:0] OP_SEL_B = 2'b01;

  // Maps the k-th bit on the wire (k=0 first) to its position in the 16-bit word.
  function automatic logic [3:0] wire_bit_idx(input logic [3:0] k);
`ifdef SPI_MASTER_BYTE_SWAP_EN
    return {k[3], ~k[2:0]};
`else
    return ~k;
`endif
  endfunction

endpackage

// File: rtl/spi_dep_signal_synchronizer.sv
// Two-flop synchronizer for signals entering the clk_i domain.
module spi_dep_signal_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// SPI mode-0 initiator: one CS-framed 16-bit transfer per accepted command word.
// SPI_MASTER_BYTE_SWAP_EN: low byte first on the wire (each byte MSB first).
module sobel_gcd_spi_master
  import sobel_gcd_spi_pkg::*;
#(
  parameter int unsigned STREAM_DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV           = 4,
  parameter int unsigned CS_SETUP_CYCLES   = 2,
  parameter int unsigned CS_HOLD_CYCLES    = 2,
  parameter int unsigned GAP_CYCLES        = 4
) (
  input  logic                         clk_i,
  input  logic                         nreset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [STREAM_DATA_WIDTH-1:0] req_data_i,
  output logic                         rsp_valid_o,
  output logic [STREAM_DATA_WIDTH-1:0] rsp_data_o,
  output logic                         busy_o,
  output logic                         spi_sck_o,
  output logic                         spi_sdo_o,
  input  logic                         spi_sdi_i,
  output logic                         spi_cs_o
);

  // Request port: a word transfers on a clock edge where req_valid_i and req_ready_o are
  // both high; ready is asserted only in S_IDLE and does not depend on req_valid_i.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_e                         state_q;
  logic [7:0]                     cnt_q;
  logic [3:0]                     bit_q;
  logic                           sck_q;
  logic                           cs_q;
  logic                           sdo_q;
  logic                           ready_q;
  logic                           rsp_valid_q;
  logic [STREAM_DATA_WIDTH-1:0]   tx_q;
  logic [STREAM_DATA_WIDTH-1:0]   rx_q;
  logic [STREAM_DATA_WIDTH-1:0]   rsp_data_q;
  logic                           sdi_sync;

  spi_dep_signal_synchronizer #(.WIDTH(1)) u_sdi_sync (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d_i      (spi_sdi_i),
    .q_o      (sdi_sync)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      sdo_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            state_q <= S_CS_SETUP;
            tx_q    <= req_data_i;
            cs_q    <= 1'b0;
            sdo_q   <= req_data_i[wire_bit_idx(4'd0)];
            ready_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        S_CS_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SHIFT: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            // End of a high phase: sample MISO, then the falling edge launches the next bit.
            if (sck_q) begin
              rx_q[wire_bit_idx(bit_q)] <= sdi_sync;
              if (bit_q == 4'd15) begin
                state_q <= S_CS_HOLD;
                sdo_q   <= 1'b0;
              end else begin
                bit_q <= bit_q + 4'd1;
                sdo_q <= tx_q[wire_bit_idx(bit_q + 4'd1)];
              end
            end
          end
        end
        S_CS_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= S_GAP;
            cnt_q       <= '0;
            cs_q        <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign spi_sck_o   = sck_q;
  assign spi_sdo_o   = sdo_q;
  assign spi_cs_o    = cs_q;

endmodule

// File: tb/tb_sobel_gcd_spi_master.sv
// Bench for sobel_gcd_spi_master: default-timing instance plus a CLK_DIV=3 instance,
// each driven against a mode-0 slave model; responses checked through a scoreboard queue.
module tb_sobel_gcd_spi_master;
  import sobel_gcd_spi_pkg::*;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] cyc = '0;

  logic [1:0]  req_valid = '0;
  logic [1:0]  ready;
  logic [15:0] req_data [2];
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data [2];
  logic [1:0]  busy;
  logic [1:0]  sck;
  logic [1:0]  sdo;
  logic [1:0]  sdi = '0;
  logic [1:0]  cs;

  // Scoreboard: {instance, expected cycle, expected data}; MOSI queue: {instance, check, wire word}.
  logic [48:0] exp_q[$];
  logic [17:0] mosi_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Slave model state
  logic [15:0] slv_word [2];
  logic [15:0] s_tx [2];
  logic [15:0] s_mosi [2];
  int          s_idx [2];
  int          s_rises [2];
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sck = 2'b00;
  logic [12:0] op_a = '0;
  logic [12:0] op_b = '0;
  logic [7:0]  pix = '0;

  sobel_gcd_spi_master dut (
    .clk_i(clk), .nreset_i(nreset),
    .req_valid_i(req_valid[0]), .req_ready_o(ready[0]), .req_data_i(req_data[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]), .busy_o(busy[0]),
    .spi_sck_o(sck[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0]), .spi_cs_o(cs[0])
  );

  sobel_gcd_spi_master #(.CLK_DIV(3)) dut3 (
    .clk_i(clk), .nreset_i(nreset),
    .req_valid_i(req_valid[1]), .req_ready_o(ready[1]), .req_data_i(req_data[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]), .busy_o(busy[1]),
    .spi_sck_o(sck[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1]), .spi_cs_o(cs[1])
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] to_wire(input logic [15:0] w);
`ifdef SPI_MASTER_BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input int g, input logic [15:0] d, input logic [15:0] slv,
                       input logic [31:0] lat, input bit completes, output logic [31:0] t0);
    int guard;
    guard = 0;
    req_valid[g] = 1'b1;
    req_data[g]  = d;
    slv_word[g]  = slv;
    while (!ready[g] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: inst %0d never ready", g);
    end
    t0 = cyc;
    if (completes) begin
      exp_q.push_back({g[0], t0 + lat, slv});
      mosi_q.push_back({g[0], 1'b1, to_wire(d)});
    end else begin
      mosi_q.push_back({g[0], 1'b0, 16'h0000});
    end
  endtask

  task automatic wait_ready(input int g, output logic [31:0] t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready[g] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: inst %0d", g);
    end
    t = cyc;
  endtask

  task automatic wait_sck(input int g, output logic [31:0] t);
    int guard;
    guard = 0;
    while (!sck[g] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL sck_timeout: inst %0d", g);
    end
    t = cyc;
  endtask

  // ---------------- slave model + monitor ----------------
  always @(negedge clk) begin
    logic [48:0] e;
    logic [17:0] m;
    logic [15:0] w;
    for (int g = 0; g < 2; g++) begin
      if (rsp_valid[g]) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_unexpected: inst %0d data 0x%0h, expected no response", g, rsp_data[g]);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_inst", g, {31'd0, e[48]});
          chk("rsp_data", {16'd0, rsp_data[g]}, {16'd0, e[15:0]});
          chk("rsp_cycle", cyc, e[47:16]);
        end
      end

      if (!cs[g] && prev_cs[g]) begin
        s_tx[g]    = to_wire(slv_word[g]);
        s_idx[g]   = 0;
        s_rises[g] = 0;
        s_mosi[g]  = '0;
        sdi[g]     = s_tx[g][15];
      end else if (!cs[g]) begin
        if (sck[g] && !prev_sck[g]) begin
          s_mosi[g] = {s_mosi[g][14:0], sdo[g]};
          s_rises[g]++;
        end
        if (!sck[g] && prev_sck[g] && s_idx[g] < 15) begin
          s_idx[g]++;
          sdi[g] = s_tx[g][15 - s_idx[g]];
        end
      end

      if (cs[g] && !prev_cs[g]) begin
        if (mosi_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL frame_unexpected: inst %0d mosi 0x%0h, expected no frame", g, s_mosi[g]);
        end else begin
          m = mosi_q.pop_front();
          if (m[16]) begin
            chk("frame_inst", g, {31'd0, m[17]});
            chk("sck_rises", s_rises[g], 32'd16);
            chk("mosi_word", {16'd0, s_mosi[g]}, {16'd0, m[15:0]});
            w = to_wire(s_mosi[g]);
            if (g == 0) begin
              if (!w[CMD_SOBEL_BIT]) begin
                if (w[OP_SEL_MSB:OP_SEL_LSB] == OP_SEL_A) op_a = w[12:0];
                else if (w[OP_SEL_MSB:OP_SEL_LSB] == OP_SEL_B) op_b = w[12:0];
              end else begin
                pix = w[7:0];
              end
            end
          end
        end
      end
      prev_cs[g]  = cs[g];
      prev_sck[g] = sck[g];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t0, t1, t;
    logic        act;
    req_data[0] = '0; req_data[1] = '0;
    slv_word[0] = '0; slv_word[1] = '0;

    // Reset
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk("reset_outputs", {9'd0, cs[g], sck[g], sdo[g], ready[g], rsp_valid[g], busy[g], 1'b0, rsp_data[g]},
          {9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    nreset = 1'b1;
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      act = act | sck[0] | sck[1] | ~cs[0] | ~cs[1] | ~ready[0] | ~ready[1];
    end
    chk("idle_after_reset", {31'd0, act}, 32'd0);

    // Single frame
    @(negedge clk);
    issue(0, 16'hA55A, 16'h1234, 32'd133, 1'b1, t0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("frame_start_outs", {29'd0, cs[0], busy[0], ready[0]}, {29'd0, 1'b0, 1'b1, 1'b0});
    wait_sck(0, t);
    chk("first_sck_rise", t, t0 + 32'd7);
    wait_ready(0, t);
    chk("ready_return", t, t0 + 32'd137);

    // Back-to-back with req_valid held
    issue(0, 16'h0012, 16'h4321, 32'd133, 1'b1, t0);
    repeat (2) @(negedge clk);
    issue(0, 16'h2030, 16'h8765, 32'd133, 1'b1, t1);
    chk("b2b_accept_gap", t1 - t0, 32'd137);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_ready(0, t);
    chk("b2b_ready_return", t, t1 + 32'd137);
    chk("slave_op_a", {19'd0, op_a}, 32'h12);
    chk("slave_op_b", {19'd0, op_b}, 32'h30);

    // Reset during shift, after the 5th SCK rising edge
    issue(0, 16'h5A5A, 16'hFFFF, 32'd0, 1'b0, t0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    begin
      int rises, guard;
      logic ps;
      rises = 0; guard = 0; ps = 1'b0;
      while (rises < 5 && guard < 2000) begin
        @(negedge clk);
        if (sck[0] && !ps) rises++;
        ps = sck[0];
        guard++;
      end
      chk("reset_mid_rises", rises, 32'd5);
    end
    #2 nreset = 1'b0;
    #1;
    chk("reset_mid_outputs", {9'd0, cs[0], sck[0], sdo[0], ready[0], rsp_valid[0], busy[0], 1'b0, rsp_data[0]},
        {9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, 16'h8077, 16'h0F0F, 32'd133, 1'b1, t0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_ready(0, t);
    chk("post_reset_ready", t, t0 + 32'd137);
    chk("slave_pixel", {24'd0, pix}, 32'h77);

    // CLK_DIV=3 instance
    issue(1, 16'hFFFF, 16'h00FF, 32'd101, 1'b1, t0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_sck(1, t);
    chk("div3_first_sck", t, t0 + 32'd6);
    wait_ready(1, t);
    chk("div3_ready_return", t, t0 + 32'd105);

    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", exp_q.size(), 32'd0);
    chk("mosi_queue_drained", mosi_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
